pipe_fwd_sb: RTL

PIPE_FWD_SB -- requirements
Module: pipe_fwd_sb

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_fwd_sel.sv | 53 +++++
 rtl/pipe_fwd_sb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand forward-select encoding and default widths.
package pipe_pkg;

    localparam int DW_DEF   = 32;
    localparam int RW_DEF   = 5;
    localparam int LATW_DEF = 4;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM_ALU,
        FWD_MEM_MO,
        FWD_LONG,
        FWD_ZERO
    } fwd_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// One operand's forwarding mux: r0, EX ALU, MEM ALU, MEM load, long unit, then regfile.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic [RW-1:0] r,
    input  logic [DW-1:0] rf,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic [RW-1:0] ern,
    input  logic [DW-1:0] ealu,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [RW-1:0] mrn,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mmo,
    input  logic          lwreg,
    input  logic [RW-1:0] lrn,
    input  logic [DW-1:0] ldata,
    output logic [DW-1:0] d
);

    fwd_e sel;

    always_comb begin
        sel = FWD_RF;
        if (r == '0)
            sel = FWD_ZERO;
        else if (ewreg && !em2reg && ern == r)
            sel = FWD_EX;
        else if (mwreg && !mm2reg && mrn == r)
            sel = FWD_MEM_ALU;
        else if (mwreg && mm2reg && mrn == r)
            sel = FWD_MEM_MO;
        else if (lwreg && lrn == r)
            sel = FWD_LONG;
    end

    always_comb begin
        d = rf;
        unique case (sel)
            FWD_ZERO:    d = '0;
            FWD_EX:      d = ealu;
            FWD_MEM_ALU: d = malu;
            FWD_MEM_MO:  d = mmo;
            FWD_LONG:    d = ldata;
            default:     d = rf;
        endcase
    end

endmodule

// File: rtl/pipe_fwd_sb.sv
// Decode-stage forwarding, load-use interlock and long-op scoreboard.
// Define PIPE_FWD_SB_STATS_EN to add the saturating stall_cycles counter.
module pipe_fwd_sb
    import pipe_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int RW   = RW_DEF,
    parameter int LATW = LATW_DEF,
    localparam int NREG = 2 ** RW
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            id_valid,
    input  logic            id_flush,
    input  logic [RW-1:0]   rs,
    input  logic [RW-1:0]   rt,
    input  logic            rs_used,
    input  logic            rt_used,
    input  logic            id_wreg,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_long,
    input  logic [LATW-1:0] id_lat,
    input  logic [DW-1:0]   ra,
    input  logic [DW-1:0]   rb,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic [RW-1:0]   ern,
    input  logic [DW-1:0]   ealu,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [RW-1:0]   mrn,
    input  logic [DW-1:0]   malu,
    input  logic [DW-1:0]   mmo,
    input  logic            lwreg,
    input  logic [RW-1:0]   lrn,
    input  logic [DW-1:0]   ldata,
    output logic [DW-1:0]   da,
    output logic [DW-1:0]   db,
    output logic            rsrtequ,
    output logic            stall,
    output logic            issue,
`ifdef PIPE_FWD_SB_STATS_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic [NREG-1:0] busy
);

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];
    logic            load_use;
    logic            sb_raw;
    logic            sb_waw;
    logic            id_live;

    pipe_fwd_sel #(.DW(DW), .RW(RW)) u_sel_a (
        .r(rs), .rf(ra),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .malu(malu), .mmo(mmo),
        .lwreg(lwreg), .lrn(lrn), .ldata(ldata),
        .d(da)
    );

    pipe_fwd_sel #(.DW(DW), .RW(RW)) u_sel_b (
        .r(rt), .rf(rb),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .ealu(ealu),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .malu(malu), .mmo(mmo),
        .lwreg(lwreg), .lrn(lrn), .ldata(ldata),
        .d(db)
    );

    assign rsrtequ = (da == db);
    assign id_live = id_valid & ~id_flush;

    always_comb begin
        load_use = ewreg & em2reg & (ern != '0)
                 & ((rs_used & (ern == rs)) | (rt_used & (ern == rt)));
        // cnt==1 means the long result is on the writeback bus now
        sb_raw = (rs_used & (cnt_q[rs] > LATW'(1)))
               | (rt_used & (cnt_q[rt] > LATW'(1)));
        sb_waw = (id_wreg | id_long) & (id_rd != '0)
               & (cnt_q[id_rd] != '0);
        stall  = id_live & (load_use | sb_raw | sb_waw);
        issue  = id_live & ~stall;
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - LATW'(1);
            if (issue && id_long && id_rd == RW'(r))
                cnt_d[r] = (id_lat == '0) ? LATW'(1) : id_lat;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++)
            busy[r] = (cnt_q[r] != '0);
    end

`ifdef PIPE_FWD_SB_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
